param_sync_ram: RTL

Parametrised single-port synchronous RAM, the successor to the fixed 64x8 part.
- Width, depth and read-during-write mode are configurable.
- A hardware clear sequencer zeroes every word after reset, with Ready/Busy status.
- A Valid strobe and an address-range error flag accompany every access.
- Used as general scratch storage; the owning logic polls Ready before issuing accesses.

---
 rtl/param_ram_pkg.sv | 18 +
 rtl/param_ram_clear_fsm.sv | 60 ++++++
 rtl/param_sync_ram.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/param_ram_pkg.sv
// -----------------------------------------------------------------------------
// param_ram_pkg
// Shared types and constants for the parametrised single-port RAM.
//   state_e          : sequencer state (ST_CLEAR while zeroing, ST_RUN afterwards)
//   MODE_READ_FIRST  : read-during-write returns the old word
//   MODE_WRITE_FIRST : read-during-write returns the new word
// -----------------------------------------------------------------------------
package param_ram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam int unsigned MODE_READ_FIRST  = 0;
   localparam int unsigned MODE_WRITE_FIRST = 1;

endpackage

// File: rtl/param_ram_clear_fsm.sv
// -----------------------------------------------------------------------------
// param_ram_clear_fsm
// Post-reset clear sequencer. Walks a counter over every word, asking the RAM
// to write zero, then parks in ST_RUN until the next reset.
// Ports:
//   i_clk       rising-edge clock
//   i_rst       asynchronous active-high reset; restarts the clear at word 0
//   o_state     current sequencer state
//   o_ready     1 once the clear has finished (registered)
//   o_busy      1 while the clear runs; always ~o_ready
//   o_clr_we    clear write request for the current cycle
//   o_clr_addr  word being cleared this cycle
// -----------------------------------------------------------------------------
module param_ram_clear_fsm
   import param_ram_pkg::*;
#(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output state_e            o_state,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_clr_we,
   output logic [ADDR_W-1:0] o_clr_addr
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   state_e            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         if (r_state == ST_CLEAR) begin
            // The edge that clears the last word also hands over to ST_RUN.
            if (r_cnt == LastAddr) begin
               r_state <= ST_RUN;
               r_ready <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         // ST_RUN is left only through reset.
      end
   end

   assign o_state    = r_state;
   assign o_ready    = r_ready;
   assign o_busy     = ~r_ready;
   assign o_clr_we   = (r_state == ST_CLEAR);
   assign o_clr_addr = r_cnt;

endmodule

// File: rtl/param_sync_ram.sv
// -----------------------------------------------------------------------------
// param_sync_ram
// Parametrised single-port synchronous RAM with a post-reset clear sequencer,
// a Valid strobe per access and an out-of-range address flag.
// Optional feature macro: RAM_OUTREG_EN adds one output pipeline stage
// (Out/Valid/AddrErr latency 2 instead of 1, full throughput kept).
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   ChipSelect  access request, sampled on the rising edge
//   Write       1 = write, 0 = read
//   Address     word address (unsigned, never wrapped)
//   In          write data
//   Out         registered read data; 0 when no valid access
//   Valid       one-cycle strobe, Out holds the access result
//   AddrErr     strobes with Valid when Address >= DEPTH
//   Ready       1 when accesses are accepted
//   Busy        1 while the clear sequence runs
// -----------------------------------------------------------------------------
module param_sync_ram
   import param_ram_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned DEPTH       = 64,  // 1 <= DEPTH <= 2**ADDR_W
   parameter int unsigned WRITE_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ChipSelect,
   input  logic              Write,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] In,
   output logic [DATA_W-1:0] Out,
   output logic              Valid,
   output logic              AddrErr,
   output logic              Ready,
   output logic              Busy
);

   state_e            w_state;
   logic              w_clr_we;
   logic [ADDR_W-1:0] w_clr_addr;

   param_ram_clear_fsm #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_fsm (
      .i_clk      (clk),
      .i_rst      (rst),
      .o_state    (w_state),
      .o_ready    (Ready),
      .o_busy     (Busy),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   // Extra MSB so DEPTH == 2**ADDR_W is representable.
   logic w_in_range;
   assign w_in_range = ({1'b0, Address} < (ADDR_W + 1)'(DEPTH));

   logic w_access;
   logic w_user_we;
   assign w_access  = (w_state == ST_RUN) && ChipSelect;
   assign w_user_we = w_access && Write && w_in_range;

   // Clear sequencer owns the port while it runs; a write sampled while rst is
   // high is suppressed.
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;
   assign w_mem_we    = (w_clr_we | w_user_we) & ~rst;
   assign w_mem_addr  = w_clr_we ? w_clr_addr : Address;
   assign w_mem_wdata = w_clr_we ? '0 : In;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   // Out-of-range reads are masked below, so the raw lookup is never used then.
   logic [DATA_W-1:0] w_rd_data;
   assign w_rd_data = r_mem[Address];

   logic [DATA_W-1:0] w_out_d;
   logic              w_valid_d;
   logic              w_err_d;

   always_comb begin
      w_out_d   = '0;
      w_valid_d = 1'b0;
      w_err_d   = 1'b0;
      if (w_access) begin
         w_valid_d = 1'b1;
         if (w_in_range) begin
            if (Write && (WRITE_FIRST == MODE_WRITE_FIRST)) begin
               w_out_d = In;
            end else begin
               w_out_d = w_rd_data;
            end
         end else begin
            w_err_d = 1'b1;
         end
      end
   end

   logic [DATA_W-1:0] r_out;
   logic              r_valid;
   logic              r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_out   <= w_out_d;
         r_valid <= w_valid_d;
         r_err   <= w_err_d;
      end
   end

`ifdef RAM_OUTREG_EN
   logic [DATA_W-1:0] r_out_p;
   logic              r_valid_p;
   logic              r_err_p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_p   <= '0;
         r_valid_p <= 1'b0;
         r_err_p   <= 1'b0;
      end else begin
         r_out_p   <= r_out;
         r_valid_p <= r_valid;
         r_err_p   <= r_err;
      end
   end

   assign Out     = r_out_p;
   assign Valid   = r_valid_p;
   assign AddrErr = r_err_p;
`else
   assign Out     = r_out;
   assign Valid   = r_valid;
   assign AddrErr = r_err;
`endif

endmodule
